traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter pGREEN_NS, default 30, north-south green duration in seconds (1..100).
REQ-002 Parameter pGREEN_EW, default 25, east-west green duration in seconds (1..100).
REQ-003 Parameter pYELLOW, default 3, yellow duration in seconds for both directions (1..100).
REQ-004 Parameter pALLRED, default 2, all-red clearance duration in seconds (1..100).
REQ-005 Parameter pPED_CUT, default 5, green time left after a pedestrian cut (1..100).
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  advance enable; when 0, phase state and timer are frozen.
REQ-009 sec_tick  in  1  one-cycle pulse per second, driven by the second counter's last output.
REQ-010 ped_req  in  1  pedestrian request pulse, latched internally.
REQ-011 ns_light  out  3  north-south lamps {R,Y,G}, one-hot.
REQ-012 ew_light  out  3  east-west lamps {R,Y,G}, one-hot.
REQ-013 phase  out  3  current state encoding.
REQ-014 remaining  out  7  seconds left in current phase minus one.
REQ-015 phase_last  out  1  high while remaining == 0.
REQ-016 ped_pending  out  1  latched pedestrian request.

Function
REQ-017 FSM states, in cycle order: NS_GREEN(0), NS_YELLOW(1), ALLRED_A(2), EW_GREEN(3), EW_YELLOW(4), ALLRED_B(5); next after ALLRED_B is NS_GREEN.
REQ-018 Lamps: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010; ALLRED_A/B ns=100 ew=100.
REQ-019 Lamp outputs are registered decodes of the state, updated in the same edge as the state.
REQ-020 Qualified tick = sec_tick & en; no other input advances the timer or FSM.
REQ-021 On a qualified tick with remaining > 0, remaining decrements by 1 and the state holds.
REQ-022 On a qualified tick with remaining == 0, the state advances to the next state and remaining loads that state's duration - 1.
REQ-023 Each phase therefore lasts exactly its duration in qualified ticks.
REQ-024 ped_pending sets on ped_req in any state and clears on entry to NS_YELLOW or EW_YELLOW; set wins if both occur in the same cycle.
REQ-025 In a green state with ped_pending = 1 and remaining > pPED_CUT - 1, a qualified tick loads remaining = pPED_CUT - 1 instead of decrementing.
REQ-026 In non-green states, or with remaining <= pPED_CUT - 1, ped_pending has no effect on the timer.
REQ-027 en = 0 while sec_tick pulses: state, remaining and lamps hold, and ped_req is still latched.
REQ-028 A green lamp is never asserted on both directions in any cycle, and a green state is always entered from ALLRED_A or ALLRED_B.
REQ-029 Illegal state encodings 6 and 7 transition to ALLRED_B with remaining = pALLRED - 1 on the next edge.

Reset
REQ-030 While rst = 1 at a clock edge: phase = ALLRED_B, remaining = pALLRED - 1, ns_light = ew_light = 100, ped_pending = 0, phase_last = (pALLRED == 1).
REQ-031 rst has priority over en, sec_tick and ped_req, and takes effect mid-phase with no completion of the current phase.
REQ-032 After reset, the first green is NS_GREEN, reached after pALLRED qualified ticks.

Structure
REQ-033 Shared package traffic_pkg holds the state encodings, the lamp constants (RED = 100, YEL = 010, GRN = 001) and the 7-bit remaining width.
REQ-034 The timer is one sub-module, phase_timer: a loadable 7-bit down counter with load, load_val, dec and zero flag; the FSM and ped latch stay in traffic_phase_ctrl.

Verification
Bench parameters: pGREEN_NS = 5, pGREEN_EW = 4, pYELLOW = 2, pALLRED = 1, pPED_CUT = 2; sec_tick every 4 clocks.
REQ-035 Reset, then en = 1 -> ALLRED_B for 1 tick, then NS_GREEN with remaining 4,3,2,1,0; full cycle of 5/2/1/4/2/1 ticks; lamps match REQ-018.
REQ-036 ped_req in NS_GREEN at remaining = 4 -> next tick remaining = 1, then 0, then NS_YELLOW; ped_pending clears on that entry.
REQ-037 ped_req in NS_GREEN at remaining = 1 -> normal decrement to 0; ped_pending clears on entering NS_YELLOW.
REQ-038 en = 0 for 3 ticks mid EW_GREEN -> state and remaining unchanged; resume continues from the held value.
REQ-039 rst asserted in EW_YELLOW -> next edge phase = 5, both lamps 100, ped_pending = 0.
REQ-040 Continuous assertion: never ns_light = 001 and ew_light = 001 together; each lamp output always one-hot.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: phase encodings,
// lamp patterns, timer width and small decode helpers.
package traffic_pkg;

  localparam int REM_W = 7;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_e;

  // Lamp patterns, bit order {R,Y,G}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Successor in the fixed phase rotation; unknown codes recover to ALLRED_B
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    logic [2:0] n;
    n = ALLRED_B;
    case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALLRED_A;
      ALLRED_A:  n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALLRED_B;
      ALLRED_B:  n = NS_GREEN;
      default:   n = ALLRED_B;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ns_lamp(input logic [2:0] p);
    logic [2:0] l;
    l = RED;
    case (p)
      NS_GREEN:  l = GRN;
      NS_YELLOW: l = YEL;
      default:   l = RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input logic [2:0] p);
    logic [2:0] l;
    l = RED;
    case (p)
      EW_GREEN:  l = GRN;
      EW_YELLOW: l = YEL;
      default:   l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter holding the seconds left in the current phase
// (minus one). Load has priority over decrement; decrement stops at zero.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [REM_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REM_W-1:0] load_val,
  input  logic             dec,
  output logic [REM_W-1:0] value,
  output logic             zero
);

  logic [REM_W-1:0] cnt_reg;

  // Counter register: reset value, then load, then saturating decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RST_VAL;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign value = cnt_reg;
  assign zero  = (cnt_reg == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with pedestrian green cut.
// The FSM and pedestrian latch live here; the seconds countdown is in
// phase_timer.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int pGREEN_NS = 30,
  parameter int pGREEN_EW = 25,
  parameter int pYELLOW   = 3,
  parameter int pALLRED   = 2,
  parameter int pPED_CUT  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sec_tick,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [2:0]       phase,
  output logic [REM_W-1:0] remaining,
  output logic             phase_last,
  output logic             ped_pending
);

  localparam logic [REM_W-1:0] NS_M1  = REM_W'(pGREEN_NS - 1);
  localparam logic [REM_W-1:0] EW_M1  = REM_W'(pGREEN_EW - 1);
  localparam logic [REM_W-1:0] YEL_M1 = REM_W'(pYELLOW - 1);
  localparam logic [REM_W-1:0] AR_M1  = REM_W'(pALLRED - 1);
  localparam logic [REM_W-1:0] CUT_M1 = REM_W'(pPED_CUT - 1);

  logic [2:0]       state_reg;
  logic [2:0]       ns_light_reg;
  logic [2:0]       ew_light_reg;
  logic             ped_pending_reg;

  logic             tick;
  logic             is_green;
  logic             illegal;
  logic             enter_yellow;
  logic [2:0]       nxt_phase;
  logic             tmr_load;
  logic             tmr_dec;
  logic [REM_W-1:0] tmr_val;
  logic [REM_W-1:0] tmr_value;
  logic             tmr_zero;

  function automatic logic [REM_W-1:0] dur_m1(input logic [2:0] p);
    logic [REM_W-1:0] d;
    d = AR_M1;
    case (p)
      NS_GREEN:             d = NS_M1;
      EW_GREEN:             d = EW_M1;
      NS_YELLOW, EW_YELLOW: d = YEL_M1;
      default:              d = AR_M1;
    endcase
    return d;
  endfunction

  // Timer control: phase rollover, pedestrian cut, or plain countdown
  always_comb begin
    tick         = sec_tick & en;
    is_green     = (state_reg == NS_GREEN) || (state_reg == EW_GREEN);
    illegal      = (state_reg > ALLRED_B);
    nxt_phase    = next_phase(state_reg);
    enter_yellow = !illegal && tick && tmr_zero && is_green;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_val      = dur_m1(nxt_phase);
    if (illegal) begin
      tmr_load = 1'b1;
      tmr_val  = AR_M1;
    end else if (tick) begin
      if (tmr_zero) begin
        tmr_load = 1'b1;
      end else if (is_green && ped_pending_reg && (tmr_value > CUT_M1)) begin
        tmr_load = 1'b1;
        tmr_val  = CUT_M1;
      end else begin
        tmr_dec = 1'b1;
      end
    end
  end

  phase_timer #(
    .RST_VAL (AR_M1)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Phase FSM with registered lamp decode and pedestrian latch (set wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ALLRED_B;
      ns_light_reg    <= RED;
      ew_light_reg    <= RED;
      ped_pending_reg <= 1'b0;
    end else begin
      ped_pending_reg <= ped_req | (ped_pending_reg & ~enter_yellow);
      if (illegal) begin
        state_reg    <= ALLRED_B;
        ns_light_reg <= RED;
        ew_light_reg <= RED;
      end else if (tick && tmr_zero) begin
        state_reg    <= nxt_phase;
        ns_light_reg <= ns_lamp(nxt_phase);
        ew_light_reg <= ew_lamp(nxt_phase);
      end
    end
  end

  assign phase       = state_reg;
  assign ns_light    = ns_light_reg;
  assign ew_light    = ew_light_reg;
  assign remaining   = tmr_value;
  assign phase_last  = tmr_zero;
  assign ped_pending = ped_pending_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short phase durations.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sec_tick;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [6:0] remaining;
  logic       phase_last;
  logic       ped_pending;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit done     = 0;

  traffic_phase_ctrl #(
    .pGREEN_NS (5),
    .pGREEN_EW (4),
    .pYELLOW   (2),
    .pALLRED   (1),
    .pPED_CUT  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sec_tick    (sec_tick),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .phase       (phase),
    .remaining   (remaining),
    .phase_last  (phase_last),
    .ped_pending (ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps from the phase table
  function automatic logic [5:0] exp_lamps(input int p);
    case (p)
      0:       return {3'b001, 3'b100};
      1:       return {3'b010, 3'b100};
      3:       return {3'b100, 3'b001};
      4:       return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Safety monitor: lamps one-hot, never green both ways
  always @(negedge clk) begin
    if (!done) begin
      chk_cnt++;
      if (!$onehot(ns_light) || !$onehot(ew_light) ||
          (ns_light == 3'b001 && ew_light == 3'b001))
        $display("FAIL lamp_safety ns=%b ew=%b (required one-hot, not both green)", ns_light, ew_light);
      else
        pass_cnt++;
    end
  end

  // One qualified-tick slot: pulse for one cycle, 4 cycles per tick; ends at negedge
  task automatic do_tick();
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  task automatic expect_state(input string tag, input int ep, input int er);
    logic [5:0] el;
    el = exp_lamps(ep);
    chk_cnt++;
    if (phase !== 3'(ep) || remaining !== 7'(er) ||
        ns_light !== el[5:3] || ew_light !== el[2:0] || phase_last !== (er == 0))
      $display("FAIL %s phase=%0d rem=%0d ns=%b ew=%b last=%b (required phase=%0d rem=%0d ns=%b ew=%b last=%b)",
               tag, phase, remaining, ns_light, ew_light, phase_last,
               ep, er, el[5:3], el[2:0], (er == 0));
    else begin
      pass_cnt++;
      $display("%s: phase=%0d rem=%0d ns=%b ew=%b ped=%b", tag, phase, remaining, ns_light, ew_light, ped_pending);
    end
  endtask

  task automatic expect_ped(input string tag, input logic ev);
    chk_cnt++;
    if (ped_pending !== ev)
      $display("FAIL %s ped_pending=%b (required %b)", tag, ped_pending, ev);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sec_tick = 1'b0; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    expect_state("reset", 5, 0);
    expect_ped("reset_ped", 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_cycle();
    int ep[16] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
    int er[16] = '{4, 3, 2, 1, 0, 1, 0, 0, 3, 2, 1, 0, 1, 0, 0, 4};
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_tick();
      expect_state($sformatf("cycle_t%0d", i), ep[i], er[i]);
    end
  endtask

  task automatic test_ped_cut();
    pulse_ped();
    expect_ped("cut_latched", 1'b1);
    expect_state("cut_no_tick", 0, 4);
    do_tick(); expect_state("cut_load", 0, 1);
    do_tick(); expect_state("cut_dec", 0, 0);
    do_tick(); expect_state("cut_yellow", 1, 1);
    expect_ped("cut_clear", 1'b0);
    do_tick(); expect_state("cut_y0", 1, 0);
    do_tick(); expect_state("cut_allred", 2, 0);
    do_tick(); expect_state("cut_ewg", 3, 3);
  endtask

  task automatic test_en_hold();
    do_tick(); expect_state("hold_pre", 3, 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      expect_state($sformatf("hold_t%0d", i), 3, 2);
    end
    pulse_ped();
    expect_ped("hold_ped_latched", 1'b1);
    en = 1'b1;
    do_tick(); expect_state("hold_resume_cut", 3, 1);
    do_tick(); expect_state("hold_resume_dec", 3, 0);
    do_tick(); expect_state("hold_ewy", 4, 1);
    expect_ped("hold_ped_clear", 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_ped();
    expect_ped("rstmid_ped_set", 1'b1);
    rst = 1'b1;
    @(negedge clk);
    expect_state("rstmid", 5, 0);
    expect_ped("rstmid_ped", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    do_tick(); expect_state("rstmid_nsg", 0, 4);
  endtask

  task automatic test_ped_late();
    do_tick(); expect_state("late_3", 0, 3);
    do_tick(); expect_state("late_2", 0, 2);
    do_tick(); expect_state("late_1", 0, 1);
    pulse_ped();
    do_tick(); expect_state("late_0", 0, 0);
    expect_ped("late_still_set", 1'b1);
    do_tick(); expect_state("late_yellow", 1, 1);
    expect_ped("late_clear", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_cut();
    test_en_hold();
    test_reset_mid();
    test_ped_late();
    done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
